// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST_MAX beats into a shared FIFO, with one IDLE bubble between grants.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [IW-1:0]   grant_q, rr_ptr_q;
  logic [CW-1:0]   beat_cnt_q;

  logic [IW-1:0]   pick_d, next_ptr_d;
  logic            sel_valid, ready_en, beat, last_beat;
  logic [DATA_WIDTH-1:0] sel_data;

  // First valid requester scanning cyclically upward from rr_ptr_q.
  always_comb begin
    logic        found;
    int unsigned idx;
    logic [IW-1:0] cand;
    pick_d = rr_ptr_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {{(32-IW){1'b0}}, rr_ptr_q} + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!found && req_valid[cand]) begin
        pick_d = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == grant_q) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    next_ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    // rst is folded in so an in-flight beat is suppressed on the reset edge.
    busy       = rst && (state_q == GRANT);
    ready_en   = busy && !fifo_full;
    beat       = ready_en && sel_valid;
    last_beat  = (beat_cnt_q == CW'(BURST_MAX - 1));
    fifo_wr_en = beat;
    fifo_din   = beat ? sel_data : '0;
    grant_id   = grant_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = ready_en && (IW'(i) == grant_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q    <= pick_d;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (!sel_valid) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr_d;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_beat) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with per-requester word sources.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]   fifo_din;
  logic            fifo_wr_en, fifo_full, busy;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0]   en;
  int unsigned     cnt [NR];
  int unsigned     lim [NR];
  logic [DW-1:0]   base [NR];

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic setup(input int i, input logic [DW-1:0] b, input int unsigned l);
    base[i] = b;
    lim[i]  = l;
    cnt[i]  = 0;
  endtask

  // Present each source's next word; a source is valid while it has words left.
  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = en[i] && (cnt[i] < lim[i]);
      req_data[i*DW +: DW] = base[i] + DW'(cnt[i]);
    end
    #1;
  endtask

  task automatic advance();
    for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) cnt[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = '1;
    for (int i = 0; i < NR; i++) setup(i, DW'(32'h100 * i), 10);
    for (int c = 0; c < 3; c++) begin
      apply();
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready c=%0d got %b exp 0000", c, req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr c=%0d got %b exp 0", c, fifo_wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d got %b exp 0", c, busy); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid c=%0d got %0d exp 0", c, grant_id); end
      advance();
    end
    en = '0;
  endtask

  task automatic test_single();
    bit          e_busy [10] = '{0,1,1,1,1,0,1,1,1,0};
    bit          e_wr   [10] = '{0,1,1,1,1,0,1,1,0,0};
    int unsigned e_din  [10] = '{0,'h200,'h201,'h202,'h203,0,'h204,'h205,0,0};
    logic [NR-1:0] e_rdy;
    rst = 1'b1;
    fifo_full = 1'b0;
    setup(2, 32'h200, 6);
    en = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      apply();
      e_rdy = e_busy[c] ? 4'b0100 : 4'b0000;
      checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, e_busy[c]); end
      checks++; if (fifo_wr_en !== e_wr[c]) begin errors++; $display("FAIL single_wr c=%0d got %b exp %b", c, fifo_wr_en, e_wr[c]); end
      checks++; if (fifo_din !== e_din[c]) begin errors++; $display("FAIL single_din c=%0d got %h exp %h", c, fifo_din, e_din[c]); end
      checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL single_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
      if (c > 0) begin
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid c=%0d got %0d exp 2", c, grant_id); end
      end
      advance();
    end
    en = '0;
  endtask

  task automatic test_round_robin();
    int  writes = 0;
    int  phase, g;
    logic [DW-1:0] e_din;
    rst = 1'b0;
    en  = '0;
    apply();
    advance();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) setup(i, DW'(32'h1000 * (i + 1)), 100);
    en = '1;
    for (int c = 0; c < 25; c++) begin
      apply();
      phase = c % 5;
      g     = (c / 5) % 4;
      e_din = (phase != 0) ? base[g] + DW'((c / 20) * 4 + phase - 1) : '0;
      if (fifo_wr_en) writes++;
      checks++; if (fifo_wr_en !== (phase != 0)) begin errors++; $display("FAIL rr_wr c=%0d got %b exp %b", c, fifo_wr_en, phase != 0); end
      checks++; if (fifo_din !== e_din) begin errors++; $display("FAIL rr_din c=%0d got %h exp %h", c, fifo_din, e_din); end
      if (phase != 0) begin
        checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL rr_gid c=%0d got %0d exp %0d", c, grant_id, g); end
      end
      advance();
    end
    checks++; if (writes != 20) begin errors++; $display("FAIL rr_writes got %0d exp 20", writes); end
    en = '0;
    apply();
    advance();
  endtask

  task automatic test_fifo_full();
    bit          e_busy [11] = '{0,1,1,1,1,1,1,1,1,1,0};
    bit          e_wr   [11] = '{0,1,1,0,0,0,0,0,1,1,0};
    int unsigned e_din  [11] = '{0,'h100,'h101,0,0,0,0,0,'h102,'h103,0};
    logic [NR-1:0] e_rdy;
    setup(1, 32'h100, 4);
    en = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      fifo_full = (c >= 3) && (c <= 7);
      apply();
      e_rdy = (e_busy[c] && !fifo_full) ? 4'b0010 : 4'b0000;
      checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL full_busy c=%0d got %b exp %b", c, busy, e_busy[c]); end
      checks++; if (fifo_wr_en !== e_wr[c]) begin errors++; $display("FAIL full_wr c=%0d got %b exp %b", c, fifo_wr_en, e_wr[c]); end
      checks++; if (fifo_din !== e_din[c]) begin errors++; $display("FAIL full_din c=%0d got %h exp %h", c, fifo_din, e_din[c]); end
      checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL full_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
      if (e_busy[c]) begin
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL full_gid c=%0d got %0d exp 1", c, grant_id); end
      end
      advance();
    end
    fifo_full = 1'b0;
    checks++; if (cnt[1] != 4) begin errors++; $display("FAIL full_accepted got %0d exp 4", cnt[1]); end
    en = '0;
  endtask

  task automatic test_drop();
    bit          e_busy [14] = '{0,1,1,1,0,1,1,1,1,0,1,1,1,0};
    bit          e_wr   [14] = '{0,1,1,0,0,1,1,1,1,0,1,1,0,0};
    int unsigned e_din  [14] = '{0,'hA00,'hA01,0,0,'hD00,'hD01,'hD02,'hD03,0,'hA02,'hA03,0,0};
    int          e_gid  [14] = '{-1,0,0,0,-1,3,3,3,3,-1,0,0,0,-1};
    logic [NR-1:0] e_rdy;
    rst = 1'b0;
    en  = '0;
    apply();
    advance();
    rst = 1'b1;
    setup(0, 32'hA00, 4);
    setup(3, 32'hD00, 4);
    for (int c = 0; c < 14; c++) begin
      en = {1'b1, 2'b00, (c != 3)};
      apply();
      e_rdy = e_busy[c] ? 4'(1 << e_gid[c]) : 4'b0000;
      checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL drop_busy c=%0d got %b exp %b", c, busy, e_busy[c]); end
      checks++; if (fifo_wr_en !== e_wr[c]) begin errors++; $display("FAIL drop_wr c=%0d got %b exp %b", c, fifo_wr_en, e_wr[c]); end
      checks++; if (fifo_din !== e_din[c]) begin errors++; $display("FAIL drop_din c=%0d got %h exp %h", c, fifo_din, e_din[c]); end
      checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL drop_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
      if (e_gid[c] >= 0) begin
        checks++; if (grant_id !== 2'(e_gid[c])) begin errors++; $display("FAIL drop_gid c=%0d got %0d exp %0d", c, grant_id, e_gid[c]); end
      end
      advance();
    end
    en = '0;
  endtask

  task automatic test_reset_mid_burst();
    bit          e_busy [5] = '{0,1,0,0,1};
    bit          e_wr   [5] = '{0,1,0,0,1};
    int unsigned e_din  [5] = '{0,'h6000,0,0,'h5000};
    int          e_gid  [5] = '{-1,1,-1,0,0};
    logic [NR-1:0] e_rdy;
    setup(0, 32'h5000, 4);
    setup(1, 32'h6000, 4);
    en = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      rst = (c != 2);
      apply();
      e_rdy = e_busy[c] ? 4'(1 << e_gid[c]) : 4'b0000;
      checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL rstmid_busy c=%0d got %b exp %b", c, busy, e_busy[c]); end
      checks++; if (fifo_wr_en !== e_wr[c]) begin errors++; $display("FAIL rstmid_wr c=%0d got %b exp %b", c, fifo_wr_en, e_wr[c]); end
      checks++; if (fifo_din !== e_din[c]) begin errors++; $display("FAIL rstmid_din c=%0d got %h exp %h", c, fifo_din, e_din[c]); end
      checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL rstmid_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
      if (e_gid[c] >= 0) begin
        checks++; if (grant_id !== 2'(e_gid[c])) begin errors++; $display("FAIL rstmid_gid c=%0d got %0d exp %0d", c, grant_id, e_gid[c]); end
      end
      advance();
    end
    checks++; if (cnt[1] != 1) begin errors++; $display("FAIL rstmid_req1_accepted got %0d exp 1", cnt[1]); end
    en = '0;
  endtask

  initial begin
    rst       = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    en        = '0;
    for (int i = 0; i < NR; i++) setup(i, '0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_drop();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001: Parameter DATA_WIDTH SHALL default to 32; it is the width of each requester's data word and of the FIFO write word.
- REQ-002: Parameter NUM_REQ SHALL default to 4; it is the number of requesters, with a legal range of 2..8.
- REQ-003: Parameter BURST_MAX SHALL default to 4; it is the maximum number of beats accepted per grant, with a legal range of 1..16.
- REQ-004: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-005: Port rst, input, 1 bit: reset, synchronous, active-low.
- REQ-006: Port req_valid, input, NUM_REQ bits: bit i high means requester i presents a data word.
- REQ-007: Port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's word is bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-008: Port req_ready, output, NUM_REQ bits: bit i high means requester i's word is accepted this cycle if valid.
- REQ-009: Port fifo_din, output, DATA_WIDTH bits: write data to the shared FIFO.
- REQ-010: Port fifo_wr_en, output, 1 bit: FIFO write strobe.
- REQ-011: Port fifo_full, input, 1 bit: FIFO full flag.
- REQ-012: Port grant_id, output, $clog2(NUM_REQ) bits: the currently or most recently granted requester.
- REQ-013: Port busy, output, 1 bit: high while in state GRANT.

Function
- REQ-014: The FSM SHALL have two states: IDLE and GRANT.
- REQ-015: In IDLE, if any req_valid bit is high, the block SHALL select the first valid requester scanning cyclically from rr_ptr, register it into grant_id, clear beat_cnt, and enter GRANT on the next edge; the fifo_full level SHALL NOT gate this transition.
- REQ-016: rr_ptr SHALL hold the highest-priority index; on grant release it SHALL become (grant_id+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
- REQ-017: req_ready[grant_id] SHALL equal (state==GRANT) && !fifo_full, combinationally; all other req_ready bits SHALL be 0.
- REQ-018: A beat SHALL transfer when req_valid[grant_id] && req_ready[grant_id] are both high.
- REQ-019: On a beat, fifo_wr_en SHALL be 1 and fifo_din SHALL carry req_data of grant_id in the same cycle; otherwise fifo_wr_en SHALL be 0 and fifo_din SHALL be 0.
- REQ-020: beat_cnt SHALL increment on each beat.
- REQ-021: A beat with beat_cnt==BURST_MAX-1 SHALL return the FSM to IDLE and advance rr_ptr.
- REQ-022: In GRANT, if req_valid[grant_id] is low, the FSM SHALL return to IDLE and advance rr_ptr, with no beat transferred.
- REQ-023: If fifo_full is high in GRANT, the grant SHALL be held, no beat SHALL transfer, and beat_cnt and rr_ptr SHALL be unchanged; transfer SHALL resume the first cycle fifo_full is low.
- REQ-024: Latency from a valid request in IDLE to the first possible beat SHALL be 1 cycle.
- REQ-025: Every grant change SHALL incur exactly one IDLE bubble cycle, including a re-grant of the same requester.
- REQ-026: Words SHALL never be dropped or duplicated.
- REQ-027: FIFO write order SHALL equal acceptance order.
- REQ-028: Changes to req_valid of non-granted requesters SHALL NOT affect the current grant.

Reset
- REQ-029: With rst=0 at a rising edge, the block SHALL reset state to IDLE, rr_ptr to 0, beat_cnt to 0, and grant_id to 0.
- REQ-030: While in reset, busy, fifo_wr_en, fifo_din, and req_ready SHALL all be 0.
- REQ-031: Assertion of rst mid-burst SHALL abort the burst at that edge; the in-flight beat of that cycle is not written.
- REQ-032: Arbitration SHALL restart from requester 0 on the first cycle with rst=1.

Verification
- REQ-033: Hold rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, fifo_wr_en=0, busy=0, grant_id=0 throughout.
- REQ-034: Requester 2 alone, valid continuously with data 0x200..0x205 -> grant_id=2; 0x200..0x203 written on 4 consecutive cycles; 1 bubble cycle; re-grant to 2; then 0x204, 0x205 written.
- REQ-035: All 4 requesters valid continuously, fifo_full=0 -> grants in order 0,1,2,3,0, each 4 beats followed by 1 bubble; 20 writes in 25 cycles.
- REQ-036: Raise fifo_full for 5 cycles after beat 2 of requester 1 -> req_ready=0 and fifo_wr_en=0 for those 5 cycles; grant held; beats 3 and 4 written afterwards with no duplicate.
- REQ-037: Requester 0 drops valid after 2 beats while requester 3 is valid -> IDLE, then grant 3; next arbitration starts from rr_ptr=1 after 0 released.
- REQ-038: Assert rst=0 during beat 2 of a burst -> that beat is not written; outputs are at reset values next cycle; after release, requester 0 wins if valid.
